// File: rtl/wb_sram_slave_pkg.sv
// Shared types and constants for the Wishbone SRAM slave.
package wb_sram_slave_pkg;

  // Handshake FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Width of the wait-state counter; WAIT_STATES is limited to 0..15
  localparam int unsigned WaitCntWidth = 4;

  // Counter preload for a given number of wait states (unused when ws == 0)
  function automatic logic [WaitCntWidth-1:0] wait_load(input int unsigned ws);
    logic [WaitCntWidth-1:0] load;
    load = '0;
    if (ws != 0) begin
      load = WaitCntWidth'(ws - 1);
    end
    return load;
  endfunction

endpackage

// File: rtl/wb_sram_core.sv
// Single-port synchronous RAM, 32-bit words, byte write enables, read-before-write.
module wb_sram_core #(
  parameter int unsigned AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic [3:0]           we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Registered read returns the word as it was before a same-edge write
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic single-transfer slave fronting an on-chip word RAM.
module wb_sram_slave
  import wb_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  output logic [31:0] wishbone_data_o,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic        wishbone_ack_o,
  output logic        wishbone_err_o
);

  localparam logic [WaitCntWidth-1:0] WaitLoad = wait_load(WAIT_STATES);

  state_e                  state_q;
  logic [WaitCntWidth-1:0] cnt_q;
  logic [31:2]             addr_q;
  logic [31:0]             wdata_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    data_valid_q;

  logic                    req;
  logic                    in_range;
  logic                    core_en;
  logic [3:0]              core_we;
  logic [31:0]             core_rdata;

  // Byte offset bits play no part in a word-addressed RAM
  logic unused_addr;
  assign unused_addr = ^wishbone_addr_i[1:0];

  assign req      = wishbone_stb_i & wishbone_cyc_i;
  assign in_range = (addr_q[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);

  // RAM is touched only on the RESP edge; gated by rst so a reset edge never commits a write
  assign core_en = rst && (state_q == StResp) && in_range;
  assign core_we = (core_en && we_q) ? sel_q : 4'b0000;

  wb_sram_core #(
    .AddrWidth(DEPTH_LOG2)
  ) u_core (
    .clk_i  (clk),
    .en_i   (core_en),
    .we_i   (core_we),
    .addr_i (addr_q[DEPTH_LOG2+1:2]),
    .wdata_i(wdata_q),
    .rdata_o(core_rdata)
  );

  // Handshake FSM with registered ack/err and request latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= wishbone_addr_i[31:2];
            wdata_q <= wishbone_data_i;
            we_q    <= wishbone_we_i;
            sel_q   <= wishbone_sel_i;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= WaitLoad;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!req) begin
            // Master abort: drop the transfer silently
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (in_range) begin
            ack_q        <= 1'b1;
            data_valid_q <= 1'b1;
          end else begin
            err_q        <= 1'b1;
            data_valid_q <= 1'b0;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data comes straight from the RAM register; forced to zero after reset or an error
  assign wishbone_data_o = data_valid_q ? core_rdata : 32'h0;
  assign wishbone_ack_o  = ack_q;
  assign wishbone_err_o  = err_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench: three slaves (WS=1, WS=3 at a non-zero base, WS=0) against a word-array model.
module tb_wb_sram_slave;

  localparam logic [31:0] Base1 = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][31:0] adr   = '0;
  logic [2:0][31:0] dat_w = '0;
  logic [2:0][31:0] dat_r;
  logic [2:0][3:0]  sel   = '0;
  logic [2:0]       we    = '0;
  logic [2:0]       stb   = '0;
  logic [2:0]       cyc   = '0;
  logic [2:0]       ack;
  logic [2:0]       err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [3][1024];

  wb_sram_slave #(.BASE_ADDR(32'h0), .DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .rst(rst), .wishbone_addr_i(adr[0]), .wishbone_data_i(dat_w[0]),
    .wishbone_data_o(dat_r[0]), .wishbone_we_i(we[0]), .wishbone_sel_i(sel[0]),
    .wishbone_stb_i(stb[0]), .wishbone_cyc_i(cyc[0]), .wishbone_ack_o(ack[0]),
    .wishbone_err_o(err[0])
  );

  wb_sram_slave #(.BASE_ADDR(Base1), .DEPTH_LOG2(10), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst), .wishbone_addr_i(adr[1]), .wishbone_data_i(dat_w[1]),
    .wishbone_data_o(dat_r[1]), .wishbone_we_i(we[1]), .wishbone_sel_i(sel[1]),
    .wishbone_stb_i(stb[1]), .wishbone_cyc_i(cyc[1]), .wishbone_ack_o(ack[1]),
    .wishbone_err_o(err[1])
  );

  wb_sram_slave #(.BASE_ADDR(32'h0), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut2 (
    .clk(clk), .rst(rst), .wishbone_addr_i(adr[2]), .wishbone_data_i(dat_w[2]),
    .wishbone_data_o(dat_r[2]), .wishbone_we_i(we[2]), .wishbone_sel_i(sel[2]),
    .wishbone_stb_i(stb[2]), .wishbone_cyc_i(cyc[2]), .wishbone_ack_o(ack[2]),
    .wishbone_err_o(err[2])
  );

  function automatic int ws_of(input int k);
    if (k == 0) return 1;
    if (k == 1) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? Base1 : 32'h0;
  endfunction

  // 4 KiB window: everything above bit 11 must match the base
  function automatic bit in_win(input int k, input logic [31:0] a);
    return (a >> 12) == (base_of(k) >> 12);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // One classic transfer; lat counts negedges from request setup to termination (-1 on timeout).
  // post is ack|err one cycle after termination. Updates the model on in-window writes.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic got_ack, output logic got_err,
                      output logic [31:0] got_data, output int lat, output logic post);
    @(negedge clk);
    adr[k] = a; dat_w[k] = d; we[k] = w; sel[k] = s; stb[k] = 1'b1; cyc[k] = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; got_data = '0; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        got_ack = ack[k]; got_err = err[k]; got_data = dat_r[k]; lat = c;
        break;
      end
    end
    stb[k] = 1'b0; cyc[k] = 1'b0; we[k] = 1'b0;
    @(negedge clk);
    post = ack[k] | err[k];
    if (w && in_win(k, a)) mem_m[k][a[11:2]] = merge(mem_m[k][a[11:2]], d, s);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (ack[k] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d got %b exp 0", k, ack[k]); end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %b exp 0", k, err[k]); end
      checks++; if (dat_r[k] !== 32'h0) begin errors++; $display("FAIL reset_data dut%0d got %h exp 0", k, dat_r[k]); end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic a, e, p; logic [31:0] d; int lat;
    xfer(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, a, e, d, lat, p);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%b err=%b exp ack=1 err=0", a, e); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b exp 0", p); end
    xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_ack got %b exp 1", a); end
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (d !== mem_m[0][4]) begin errors++; $display("FAIL rd_data got %h exp %h", d, mem_m[0][4]); end
  endtask

  task automatic test_byte_lanes();
    logic a, e, p; logic [31:0] d; int lat;
    xfer(0, 32'h20, 1'b1, 32'h1122_3344, 4'hF, a, e, d, lat, p);
    xfer(0, 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, a, e, d, lat, p);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL lane_wr_ack got %b exp 1", a); end
    xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (d !== mem_m[0][8]) begin errors++; $display("FAIL lane_data got %h exp %h", d, mem_m[0][8]); end
    // sel = 0 write still acks but changes nothing
    xfer(0, 32'h20, 1'b1, 32'h5555_5555, 4'b0000, a, e, d, lat, p);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL sel0_ack got %b exp 1", a); end
    xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (d !== mem_m[0][8]) begin errors++; $display("FAIL sel0_data got %h exp %h", d, mem_m[0][8]); end
  endtask

  task automatic test_abort();
    logic a, e, p; logic [31:0] d; int lat; logic seen;
    xfer(1, Base1 + 32'h30, 1'b1, $urandom, 4'hF, a, e, d, lat, p);
    @(negedge clk);
    adr[1] = Base1 + 32'h30; dat_w[1] = 32'hFFFF_FFFF; we[1] = 1'b1; sel[1] = 4'hF;
    stb[1] = 1'b1; cyc[1] = 1'b1;
    @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= ack[1] | err[1]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_term got %b exp 0", seen); end
    xfer(1, Base1 + 32'h30, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (d !== mem_m[1][12]) begin errors++; $display("FAIL abort_data got %h exp %h", d, mem_m[1][12]); end
  endtask

  task automatic test_out_of_range();
    logic a, e, p; logic [31:0] d; int lat;
    xfer(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL oor_term got ack=%b err=%b exp ack=0 err=1", a, e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_data got %h exp 0", d); end
    checks++; if (lat != 3) begin errors++; $display("FAIL oor_latency got %0d exp 3", lat); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL oor_pulse got %b exp 0", p); end
    // A write that would alias onto 0x10 must not land
    xfer(0, 32'h0000_1010, 1'b1, 32'h0BAD_F00D, 4'hF, a, e, d, lat, p);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", e); end
    xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (d !== mem_m[0][4]) begin errors++; $display("FAIL alias_data got %h exp %h", d, mem_m[0][4]); end
    xfer(1, 32'h0000_0040, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL below_base got ack=%b err=%b exp ack=0 err=1", a, e); end
  endtask

  task automatic test_reset_mid();
    logic a, e, p; logic [31:0] d; int lat; logic seen;
    int delays [2] = '{1, 4};
    xfer(1, Base1 + 32'h40, 1'b1, $urandom, 4'hF, a, e, d, lat, p);
    foreach (delays[i]) begin
      @(negedge clk);
      adr[1] = Base1 + 32'h40; dat_w[1] = ~mem_m[1][16]; we[1] = 1'b1; sel[1] = 4'hF;
      stb[1] = 1'b1; cyc[1] = 1'b1;
      repeat (delays[i]) @(negedge clk);
      rst = 1'b0; stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
      @(negedge clk);
      seen = ack[1] | err[1];
      rst = 1'b1;
      repeat (5) begin @(negedge clk); seen |= ack[1] | err[1]; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_term d=%0d got %b exp 0", delays[i], seen); end
      xfer(1, Base1 + 32'h40, 1'b0, 32'h0, 4'hF, a, e, d, lat, p);
      checks++; if (d !== mem_m[1][16]) begin errors++; $display("FAIL rstmid_data d=%0d got %h exp %h", delays[i], d, mem_m[1][16]); end
    end
  endtask

  task automatic test_back_to_back();
    logic a, e, p; logic [31:0] d; int lat; logic prev; int idx; int last;
    for (int w = 0; w < 4; w++) xfer(2, 32'(w * 4), 1'b1, $urandom, 4'hF, a, e, d, lat, p);
    @(negedge clk);
    adr[2] = 32'h0; we[2] = 1'b0; sel[2] = 4'hF; stb[2] = 1'b1; cyc[2] = 1'b1;
    prev = 1'b0; idx = 0; last = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      checks++; if (ack[2] && prev) begin errors++; $display("FAIL b2b_adjacent cycle %0d got ack twice exp single", c); end
      prev = ack[2];
      if (ack[2]) begin
        checks++; if (dat_r[2] !== mem_m[2][idx]) begin errors++; $display("FAIL b2b_data word %0d got %h exp %h", idx, dat_r[2], mem_m[2][idx]); end
        checks++; if (c - last != 2) begin errors++; $display("FAIL b2b_spacing word %0d got %0d exp 2", idx, c - last); end
        last = c; idx++;
        if (idx == 4) break;
        adr[2] = 32'(idx * 4);
      end
    end
    stb[2] = 1'b0; cyc[2] = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", idx); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic a, e, p; logic [31:0] d; int lat;
    logic [31:0] addr, data, expd; logic w; logic [3:0] s; int k; bit inw;
    for (int kk = 0; kk < 3; kk++)
      for (int wd = 0; wd < 16; wd++)
        xfer(kk, base_of(kk) + 32'(wd * 4), 1'b1, $urandom, 4'hF, a, e, d, lat, p);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 2);
      addr = base_of(k) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) addr = addr ^ (32'h1 << $urandom_range(12, 31));
      w = 1'($urandom_range(0, 1)); data = $urandom; s = 4'($urandom_range(0, 15));
      inw = in_win(k, addr);
      expd = inw ? mem_m[k][addr[11:2]] : 32'h0;
      xfer(k, addr, w, data, s, a, e, d, lat, p);
      checks++; if (a !== inw || e !== !inw) begin errors++; $display("FAIL rnd_term dut%0d addr %h got ack=%b err=%b exp ack=%b", k, addr, a, e, inw); end
      checks++; if (lat != ws_of(k) + 2) begin errors++; $display("FAIL rnd_latency dut%0d got %0d exp %0d", k, lat, ws_of(k) + 2); end
      checks++; if (p !== 1'b0) begin errors++; $display("FAIL rnd_pulse dut%0d got %b exp 0", k, p); end
      if (!w || !inw) begin
        checks++; if (d !== expd) begin errors++; $display("FAIL rnd_data dut%0d addr %h got %h exp %h", k, addr, d, expd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
